// File: rtl/crossbar_rr_scheduler_pkg.sv
// rtl/crossbar_rr_scheduler_pkg.sv - shared sizing defaults and destination extract for the crossbar scheduler
package crossbar_rr_scheduler_pkg;

    localparam int PIPELINE_NUM_DEF = 32;
    localparam int DATA_WIDTH_DEF   = 32;
    localparam int SELECT_WIDTH_DEF = 5;

    // The destination port rides in the low bits of every data word.
    function automatic logic [SELECT_WIDTH_DEF-1:0] dest_of(input logic [DATA_WIDTH_DEF-1:0] word);
        return word[SELECT_WIDTH_DEF-1:0];
    endfunction

endpackage

// File: rtl/crossbar_rr_scheduler_if.sv
// rtl/crossbar_rr_scheduler_if.sv - producer and consumer handshake bundle of the crossbar scheduler
interface crossbar_rr_scheduler_if
    import crossbar_rr_scheduler_pkg::*;
#(
    parameter int PIPELINE_NUM = PIPELINE_NUM_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH*PIPELINE_NUM-1:0] in_data;
    logic [PIPELINE_NUM-1:0]            in_valid;
    logic [PIPELINE_NUM-1:0]            in_ready;
    logic [DATA_WIDTH*PIPELINE_NUM-1:0] out_data;
    logic [PIPELINE_NUM-1:0]            out_valid;
    logic [PIPELINE_NUM-1:0]            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/crossbar_rr_scheduler_rr_arbiter.sv
// rtl/crossbar_rr_scheduler_rr_arbiter.sv - round-robin arbiter for one crossbar output
module rr_arbiter
    import crossbar_rr_scheduler_pkg::*;
#(
    parameter int N  = PIPELINE_NUM_DEF,
    parameter int IW = SELECT_WIDTH_DEF
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0]  upper_req;
    logic [IW-1:0] upper_idx;
    logic          upper_hit;
    logic [IW-1:0] low_idx;
    logic          low_hit;

    // Two priority scans: requesters at or above ptr first, then wrap to the lowest overall.
    always_comb begin
        upper_req = '0;
        upper_idx = '0;
        upper_hit = 1'b0;
        low_idx   = '0;
        low_hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            upper_req[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                upper_idx = IW'(i);
                upper_hit = 1'b1;
            end
            if (req[i]) begin
                low_idx = IW'(i);
                low_hit = 1'b1;
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (enable && upper_hit) begin
            grant[upper_idx] = 1'b1;
            grant_idx        = upper_idx;
        end else if (enable && low_hit) begin
            grant[low_idx] = 1'b1;
            grant_idx      = low_idx;
        end
    end

endmodule

// File: rtl/crossbar_rr_scheduler.sv
// rtl/crossbar_rr_scheduler.sv - registered NxN crossbar with per-output round-robin arbitration and stall counter
module crossbar_rr_scheduler
    import crossbar_rr_scheduler_pkg::*;
#(
    parameter int PIPELINE_NUM = PIPELINE_NUM_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SELECT_WIDTH = SELECT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    crossbar_rr_scheduler_if.slave  bus,
    output logic [31:0]             stall_cnt
);

    localparam int N = PIPELINE_NUM;

    logic [DATA_WIDTH-1:0]   word       [N];
    logic [SELECT_WIDTH-1:0] dest       [N];
    logic [N-1:0]            req        [N];
    logic [N-1:0]            grant      [N];
    logic [SELECT_WIDTH-1:0] grant_idx  [N];
    logic [N-1:0]            grant_any;
    logic [N-1:0]            can_accept;
    logic [N-1:0]            ready;
    logic                    any_stall;

    logic [SELECT_WIDTH-1:0] ptr_q      [N];
    logic [DATA_WIDTH-1:0]   out_data_q [N];
    logic [N-1:0]            out_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_in
            assign word[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign dest[gi] = SELECT_WIDTH'(dest_of(DATA_WIDTH_DEF'(word[gi])));
        end

        for (gi = 0; gi < N; gi++) begin : g_out
            for (genvar gk = 0; gk < N; gk++) begin : g_req
                assign req[gi][gk] = bus.in_valid[gk] && (dest[gk] == SELECT_WIDTH'(gi));
            end

            // A slot takes a new word when empty or when its current word leaves this cycle.
            assign can_accept[gi] = !out_valid_q[gi] || bus.out_ready[gi];
            assign grant_any[gi]  = |grant[gi];

            rr_arbiter #(
                .N  (N),
                .IW (SELECT_WIDTH)
            ) u_arb (
                .req       (req[gi]),
                .ptr       (ptr_q[gi]),
                .enable    (can_accept[gi] && !rst),
                .grant     (grant[gi]),
                .grant_idx (grant_idx[gi])
            );

            assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_data_q[gi];
        end
    endgenerate

    // Each input requests a single output, so OR-ing the grant columns gives its ready.
    always_comb begin
        ready = '0;
        for (int j = 0; j < N; j++) begin
            ready = ready | grant[j];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign any_stall     = |(bus.in_valid & ~ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                out_data_q[j] <= '0;
                ptr_q[j]      <= '0;
            end
            out_valid_q <= '0;
            stall_cnt   <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (grant_any[j]) begin
                    out_data_q[j]  <= word[grant_idx[j]];
                    out_valid_q[j] <= 1'b1;
                    ptr_q[j]       <= (grant_idx[j] == SELECT_WIDTH'(N - 1)) ? '0
                                      : SELECT_WIDTH'(grant_idx[j] + 1'b1);
                end else if (bus.out_ready[j]) begin
                    out_valid_q[j] <= 1'b0;
                end
            end
            if (any_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// tb/tb_crossbar_rr_scheduler.sv - directed bench with a per-cycle reference model of the crossbar scheduler
module tb_crossbar_rr_scheduler;

    localparam int N  = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    crossbar_rr_scheduler_if #(.PIPELINE_NUM(N), .DATA_WIDTH(DW)) bus ();

    crossbar_rr_scheduler #(
        .PIPELINE_NUM (N),
        .DATA_WIDTH   (DW),
        .SELECT_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what each output slot holds and where each output's rotation starts.
    logic [DW-1:0] m_od [N];
    logic [N-1:0]  m_ov;
    int            m_ptr [N];
    logic [31:0]   m_stall;

    initial begin
        for (int j = 0; j < N; j++) begin
            m_od[j]  = '0;
            m_ptr[j] = 0;
        end
        m_ov    = '0;
        m_stall = '0;
    end

    function automatic logic [DW-1:0] in_word(input int i);
        logic [N*DW-1:0] all;
        all = bus.in_data;
        return all[i*DW +: DW];
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           winner [N];
        logic [DW-1:0] w;
        check("out_valid", bus.out_valid, m_ov);
        check("stall_cnt", stall_cnt, m_stall);
        for (int j = 0; j < N; j++) begin
            check($sformatf("out_data[%0d]", j), bus.out_data[j*DW +: DW], m_od[j]);
        end
        exp_rdy = '0;
        for (int j = 0; j < N; j++) begin
            winner[j] = -1;
            if (!rst && (!m_ov[j] || bus.out_ready[j])) begin
                // Walk the inputs in rotation order starting from this output's pointer.
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[j] + k) % N;
                    w = in_word(i);
                    if (winner[j] < 0 && bus.in_valid[i] && (int'(w[4:0]) == j)) winner[j] = i;
                end
            end
            if (winner[j] >= 0) exp_rdy[winner[j]] = 1'b1;
        end
        check("in_ready", bus.in_ready, exp_rdy);
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                m_od[j]  = '0;
                m_ptr[j] = 0;
            end
            m_ov    = '0;
            m_stall = '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (winner[j] >= 0) begin
                    m_od[j]  = in_word(winner[j]);
                    m_ov[j]  = 1'b1;
                    m_ptr[j] = (winner[j] + 1) % N;
                end else if (bus.out_ready[j]) begin
                    m_ov[j] = 1'b0;
                end
            end
            if (|(bus.in_valid & ~exp_rdy) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid = '0;
        bus.in_data  = '0;
    endtask

    task automatic drive(input int i, input logic [DW-1:0] w);
        bus.in_data[i*DW +: DW] = w;
        bus.in_valid[i]         = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] acc;
        rst = 1'b1;
        clear_in();
        bus.out_ready = '1;
        tick();
        tick();
        rst = 1'b0;

        // Single word from input 3 to output 5.
        drive(3, 32'h0000_0025);
        #1;
        check("t1_in_ready", bus.in_ready, 32'h0000_0008);
        tick();
        clear_in();
        #1;
        check("t1_out_valid", bus.out_valid, 32'h0000_0020);
        check("t1_out_data5", bus.out_data[5*DW +: DW], 32'h0000_0025);
        check("t1_stall", stall_cnt, 32'd0);

        // Full rotate-by-one permutation at full rate.
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) drive(i, ((32'h100 + i) << 8) | ((i + 1) % N));
            #1;
            check("t2_in_ready", bus.in_ready, 32'hFFFF_FFFF);
            tick();
        end
        clear_in();
        #1;
        check("t2_out_valid", bus.out_valid, 32'hFFFF_FFFF);
        for (int j = 0; j < N; j++) begin
            check($sformatf("t2_out_data[%0d]", j), bus.out_data[j*DW +: DW],
                  ((32'h100 + ((j + N - 1) % N)) << 8) | j);
        end
        check("t2_stall", stall_cnt, 32'd0);
        tick();

        // Three inputs contend for output 7; ptr_7 is 7 so the first grant wraps to 0.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 32'hA000_0007 | (i << 8));
            #1;
            check("t3_in_ready", bus.in_ready, 32'(1) << (c % 3));
            tick();
        end
        check("t3_out_data7", bus.out_data[7*DW +: DW], 32'hA000_0207);
        check("t3_stall", stall_cnt, 32'd6);
        clear_in();
        tick();

        // Output 7 backpressured while inputs 1 and 4 wait; ptr_7 is 3.
        bus.out_ready[7] = 1'b0;
        drive(1, 32'hB000_0107);
        drive(4, 32'hB000_0407);
        #1;
        check("t4_first_grant", bus.in_ready, 32'h0000_0010);
        tick();
        check("t4_stall_a", stall_cnt, 32'd7);
        drive(4, 32'hB000_1407);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_held_ready", bus.in_ready, 32'd0);
            check("t4_held_data", bus.out_data[7*DW +: DW], 32'hB000_0407);
            tick();
        end
        check("t4_stall_b", stall_cnt, 32'd11);
        bus.out_ready[7] = 1'b1;
        #1;
        check("t4_resume_grant", bus.in_ready, 32'h0000_0002);
        tick();
        check("t4_resume_data", bus.out_data[7*DW +: DW], 32'hB000_0107);
        check("t4_stall_c", stall_cnt, 32'd12);
        clear_in();
        tick();

        // Inputs 0 and 31 alternate on output 0 across the wrap point.
        for (int c = 0; c < 4; c++) begin
            drive(0, 32'hC000_0000);
            drive(31, 32'hC000_1F00);
            #1;
            check("t5_in_ready", bus.in_ready, (c % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000);
            tick();
            check("t5_out_data0", bus.out_data[0 +: DW], (c % 2 == 0) ? 32'hC000_0000 : 32'hC000_1F00);
        end
        check("t5_stall", stall_cnt, 32'd16);
        clear_in();
        tick();

        // Load outputs 9 and 12 (ptr_12 becomes 16), then reset mid-operation.
        drive(15, 32'hD000_000C);
        drive(2, 32'hD000_0009);
        tick();
        clear_in();
        drive(9, 32'hE000_000C);
        drive(20, 32'hE000_140C);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", bus.in_ready, 32'd0);
        check("t6_pre_valid", bus.out_valid, 32'h0000_1200);
        tick();
        rst = 1'b0;
        #1;
        check("t6_post_valid", bus.out_valid, 32'd0);
        acc = '0;
        for (int j = 0; j < N; j++) acc = acc | bus.out_data[j*DW +: DW];
        check("t6_post_data", acc, 32'd0);
        check("t6_post_stall", stall_cnt, 32'd0);
        check("t6_post_grant", bus.in_ready, 32'h0000_0200);
        tick();
        check("t6_out_data12", bus.out_data[12*DW +: DW], 32'hE000_000C);
        check("t6_out_valid", bus.out_valid, 32'h0000_1000);
        clear_in();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
